// File: rtl/uart_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_mem_port_arbiter
// Description : Shares one memory port between the UART memory-mapped bridge
//               (requester 0) and a host/debug master (requester 1).
//               Round-robin arbitration, one access in flight, registered
//               memory-side strobes/address/data, watchdog abort when the
//               memory never answers.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mem_port_arbiter #(
    parameter int NUM_BYTES_DATA    = 4,
    parameter int NUM_BYTES_ADDRESS = 1,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                           clk,
    input  logic                           arst_n,
    // requester 0 (UART bridge)
    input  logic                           r0_we,
    input  logic [NUM_BYTES_DATA*8-1:0]    r0_wdata,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r0_waddr,
    input  logic                           r0_re,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r0_raddr,
    output logic [NUM_BYTES_DATA*8-1:0]    r0_rdata,
    output logic                           r0_rdy,
    output logic                           r0_err,
    // requester 1 (host/debug master)
    input  logic                           r1_we,
    input  logic [NUM_BYTES_DATA*8-1:0]    r1_wdata,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r1_waddr,
    input  logic                           r1_re,
    input  logic [NUM_BYTES_ADDRESS*8-1:0] r1_raddr,
    output logic [NUM_BYTES_DATA*8-1:0]    r1_rdata,
    output logic                           r1_rdy,
    output logic                           r1_err,
    // shared memory port
    output logic                           mem_we,
    output logic [NUM_BYTES_DATA*8-1:0]    mem_wdata,
    output logic [NUM_BYTES_ADDRESS*8-1:0] mem_waddr,
    output logic                           mem_re,
    output logic [NUM_BYTES_ADDRESS*8-1:0] mem_raddr,
    input  logic [NUM_BYTES_DATA*8-1:0]    mem_rdata,
    input  logic                           mem_rdy,
    // current owner, one-hot
    output logic [1:0]                     grant
);

    localparam int c_DW = NUM_BYTES_DATA * 8;
    localparam int c_AW = NUM_BYTES_ADDRESS * 8;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    logic [0:0]      r_state;
    logic            r_last_grant;   // 0: requester 0 owned last, 1: requester 1
    logic [1:0]      r_grant;
    logic            r_mem_we;
    logic            r_mem_re;
    logic [c_DW-1:0] r_mem_wdata;
    logic [c_AW-1:0] r_mem_waddr;
    logic [c_AW-1:0] r_mem_raddr;

    logic            w_req0;
    logic            w_req1;
    logic            w_pick0;
    logic            w_pick1;
    logic            w_timeout;
    logic            w_done;
    logic            w_rd_valid;

    // Round-robin choice: on contention the requester that did not own last wins
    always_comb begin
        w_req0  = r0_we | r0_re;
        w_req1  = r1_we | r1_re;
        w_pick0 = 1'b0;
        w_pick1 = 1'b0;
        if (w_req0 && w_req1) begin
            if (r_last_grant) begin
                w_pick0 = 1'b1;
            end else begin
                w_pick1 = 1'b1;
            end
        end else if (w_req0) begin
            w_pick0 = 1'b1;
        end else if (w_req1) begin
            w_pick1 = 1'b1;
        end
    end

    // Watchdog: counts GRANT cycles, fires on the last allowed cycle
    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdog
            localparam int c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [c_WD_W-1:0] c_TO_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

            logic [c_WD_W-1:0] r_wdog;

            // Cleared while idle so every grant starts from zero; saturates at the limit
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    r_wdog <= '0;
                end else if (r_state == c_IDLE) begin
                    r_wdog <= '0;
                end else if (r_wdog != c_TO_LAST) begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end

            // A memory answer in the same cycle takes precedence over the abort
            assign w_timeout = (r_state == c_GRANT) && (r_wdog == c_TO_LAST) && !mem_rdy;
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_done     = (r_state == c_GRANT) && (mem_rdy || w_timeout);
    assign w_rd_valid = (r_state == c_GRANT) && mem_rdy;

    // Arbitration FSM and registered memory-side outputs
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 2'b00;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_waddr  <= '0;
            r_mem_raddr  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_pick0) begin
                        // a simultaneous we/re is served as a write only
                        r_mem_we     <= r0_we;
                        r_mem_re     <= r0_re & ~r0_we;
                        r_mem_wdata  <= r0_wdata;
                        r_mem_waddr  <= r0_waddr;
                        r_mem_raddr  <= r0_raddr;
                        r_grant      <= 2'b01;
                        r_last_grant <= 1'b0;
                        r_state      <= c_GRANT;
                    end else if (w_pick1) begin
                        r_mem_we     <= r1_we;
                        r_mem_re     <= r1_re & ~r1_we;
                        r_mem_wdata  <= r1_wdata;
                        r_mem_waddr  <= r1_waddr;
                        r_mem_raddr  <= r1_raddr;
                        r_grant      <= 2'b10;
                        r_last_grant <= 1'b1;
                        r_state      <= c_GRANT;
                    end
                end
                c_GRANT: begin
                    if (w_done) begin
                        r_mem_we <= 1'b0;
                        r_mem_re <= 1'b0;
                        r_grant  <= 2'b00;
                        r_state  <= c_IDLE;
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_mem_re <= 1'b0;
                    r_grant  <= 2'b00;
                    r_state  <= c_IDLE;
                end
            endcase
        end
    end

    // Completion signalling reaches only the current owner
    always_comb begin
        r0_rdy   = w_done & r_grant[0];
        r1_rdy   = w_done & r_grant[1];
        r0_err   = w_timeout & r_grant[0];
        r1_err   = w_timeout & r_grant[1];
        r0_rdata = (w_rd_valid && r_grant[0]) ? mem_rdata : '0;
        r1_rdata = (w_rd_valid && r_grant[1]) ? mem_rdata : '0;
    end

    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_wdata = r_mem_wdata;
    assign mem_waddr = r_mem_waddr;
    assign mem_raddr = r_mem_raddr;
    assign grant     = r_grant;

endmodule
`default_nettype wire
